sram_fifo_ctrl: RTL and testbench

- Single-clock show-ahead FIFO controller that uses one 72x256 1rw1r SRAM macro as backing storage.
- Drives the macro's write port for pushes and its read port for prefetch.
- Hides the one-cycle SRAM read latency behind a 2-entry output stage.
- Sits between the debug trace capture logic (producer) and the Wishbone readout path (consumer); the SRAM macro is instantiated outside this block.

---
 rtl/sram_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// Show-ahead FIFO controller backed by an external 1rw1r SRAM macro.
// A two-slot output stage (head + skid) hides the macro's one-cycle read latency.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  sram_write_csb,
    output logic                  sram_write_web,
    output logic [NUM_WMASKS-1:0] sram_write_wmask,
    output logic [ADDR_WIDTH-1:0] sram_write_addr,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    output logic                  sram_read_csb,
    output logic [ADDR_WIDTH-1:0] sram_read_addr,
    input  logic [DATA_WIDTH-1:0] sram_read_data
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(2 ** ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      mem_cnt, mem_cnt_nxt, level_nxt;
    logic                  head_vld, skid_vld, rd_inflight;
    logic                  head_vld_nxt, skid_vld_nxt;
    logic [DATA_WIDTH-1:0] head_data, skid_data;
    logic [DATA_WIDTH-1:0] head_data_nxt, skid_data_nxt;
    logic                  push, pop, issue;
    logic [1:0]            occ;

    assign in_ready  = (mem_cnt != DEPTH_C) & ~flush;
    assign push      = in_valid & in_ready;
    assign out_valid = head_vld;
    assign out_data  = head_data;
    assign pop       = head_vld & out_ready & ~flush;

    // A pop this cycle frees a slot in time for the read issued now, which is
    // what keeps the stream at one word per cycle.
    assign occ   = {1'b0, head_vld} + {1'b0, skid_vld} + {1'b0, rd_inflight} - {1'b0, pop};
    assign issue = (mem_cnt != '0) & (occ < 2'd2) & ~flush;

    assign sram_write_csb   = ~push;
    assign sram_write_web   = ~push;
    assign sram_write_wmask = '1;
    assign sram_write_addr  = wr_ptr;
    assign sram_write_data  = in_data;
    assign sram_read_csb    = ~issue;
    assign sram_read_addr   = rd_ptr;

    always_comb begin
        mem_cnt_nxt = mem_cnt;
        case ({push, issue})
            2'b10:   mem_cnt_nxt = mem_cnt + 1'b1;
            2'b01:   mem_cnt_nxt = mem_cnt - 1'b1;
            default: mem_cnt_nxt = mem_cnt;
        endcase
    end

    always_comb begin
        head_vld_nxt  = head_vld;
        skid_vld_nxt  = skid_vld;
        head_data_nxt = head_data;
        skid_data_nxt = skid_data;
        if (pop) begin
            if (skid_vld) begin
                head_data_nxt = skid_data;
                if (rd_inflight) skid_data_nxt = sram_read_data;
                else             skid_vld_nxt  = 1'b0;
            end else if (rd_inflight) begin
                head_data_nxt = sram_read_data;
            end else begin
                head_vld_nxt = 1'b0;
            end
        end else if (rd_inflight) begin
            if (!head_vld) begin
                head_vld_nxt  = 1'b1;
                head_data_nxt = sram_read_data;
            end else begin
                skid_vld_nxt  = 1'b1;
                skid_data_nxt = sram_read_data;
            end
        end
    end

    always_comb begin
        level_nxt = mem_cnt_nxt + CNT_W'(head_vld_nxt) + CNT_W'(skid_vld_nxt) + CNT_W'(issue);
        if (flush) level_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            head_vld    <= 1'b0;
            skid_vld    <= 1'b0;
            rd_inflight <= 1'b0;
            level       <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            head_vld    <= 1'b0;
            skid_vld    <= 1'b0;
            rd_inflight <= 1'b0;
            level       <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            mem_cnt     <= mem_cnt_nxt;
            head_vld    <= head_vld_nxt;
            skid_vld    <= skid_vld_nxt;
            rd_inflight <= issue;
            level       <= level_nxt;
        end
    end

    // Data registers hold their contents across a flush so out_data stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            skid_data <= '0;
        end else if (!flush) begin
            head_data <= head_data_nxt;
            skid_data <= skid_data_nxt;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized bench for sram_fifo_ctrl with a queue-based reference model.
module tb_sram_fifo_ctrl;

    localparam int DW = 72;
    localparam int AW = 8;
    localparam int NW = 9;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic          sram_write_csb, sram_write_web, sram_read_csb;
    logic [NW-1:0] sram_write_wmask;
    logic [AW-1:0] sram_write_addr, sram_read_addr;
    logic [DW-1:0] sram_write_data, sram_read_data;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .sram_write_csb(sram_write_csb), .sram_write_web(sram_write_web),
        .sram_write_wmask(sram_write_wmask), .sram_write_addr(sram_write_addr),
        .sram_write_data(sram_write_data),
        .sram_read_csb(sram_read_csb), .sram_read_addr(sram_read_addr),
        .sram_read_data(sram_read_data)
    );

    // Simple behavioural SRAM: one-cycle registered read.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (!sram_write_csb && !sram_write_web) mem[sram_write_addr] <= sram_write_data;
        if (!sram_read_csb) sram_read_data <= mem[sram_read_addr];
    end

    int total = 0;
    int bad = 0;

    // Reference model: FIFO contents as a queue plus expected address counters.
    logic [DW-1:0] q[$];
    logic [AW-1:0] wr_cnt, rd_cnt;

    logic          o_push, o_pop, o_inrdy, o_wr, o_web, o_rd, o_ov;
    logic [DW-1:0] o_data, o_wdata, o_od, e_data;
    logic [NW-1:0] o_wmask;
    logic [AW-1:0] o_waddr, o_raddr, e_waddr, e_raddr;
    logic [AW:0]   o_level, e_level, prev_level;

    task automatic model_clear();
        q.delete();
        wr_cnt = '0;
        rd_cnt = '0;
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #2;
        prev_level = o_level;
        o_push  = in_valid & in_ready;
        o_pop   = out_valid & out_ready & ~flush;
        o_data  = out_data;
        o_inrdy = in_ready;
        o_wr    = ~sram_write_csb;
        o_web   = sram_write_web;
        o_wmask = sram_write_wmask;
        o_waddr = sram_write_addr;
        o_wdata = sram_write_data;
        o_rd    = ~sram_read_csb;
        o_raddr = sram_read_addr;
        e_waddr = wr_cnt;
        e_raddr = rd_cnt;
        e_data  = 'x;
        if (fl) begin
            model_clear();
        end else begin
            if (o_pop && q.size() > 0) e_data = q.pop_front();
            if (o_push) begin
                q.push_back(d);
                wr_cnt = wr_cnt + 1'b1;
            end
            if (o_rd) rd_cnt = rd_cnt + 1'b1;
        end
        @(posedge clk);
        #1;
        o_ov    = out_valid;
        o_od    = out_data;
        o_level = level;
        e_level = (AW+1)'(q.size());
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        o_level = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        total++; if ({sram_write_csb, sram_write_web, sram_read_csb} !== 3'b111) begin
            bad++; $display("FAIL reset_csb: got %b want 111", {sram_write_csb, sram_write_web, sram_read_csb});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            total++; if (o_wr || o_rd) begin bad++; $display("FAIL idle_csb: cyc %0d wr=%b rd=%b want 0 0", i, o_wr, o_rd); end
            total++; if (o_ov !== 1'b0 || o_level !== '0) begin
                bad++; $display("FAIL idle_state: cyc %0d ov=%b level=%0d want 0 0", i, o_ov, o_level);
            end
        end
    endtask

    task automatic test_single();
        step(1'b1, 72'h1, 1'b0, 1'b0);
        total++; if (!o_push || o_waddr !== 8'd0 || o_wdata !== 72'h1 || o_wmask !== 9'h1FF || o_web !== 1'b0) begin
            bad++; $display("FAIL single_write: push=%b addr=%0d data=%h mask=%h web=%b want 1 0 1 1ff 0", o_push, o_waddr, o_wdata, o_wmask, o_web);
        end
        total++; if (o_ov !== 1'b0) begin bad++; $display("FAIL single_lat0: out_valid=%b want 0", o_ov); end
        step(1'b0, '0, 1'b0, 1'b0);
        total++; if (!o_rd || o_raddr !== 8'd0) begin bad++; $display("FAIL single_read: rd=%b addr=%0d want 1 0", o_rd, o_raddr); end
        total++; if (o_ov !== 1'b0) begin bad++; $display("FAIL single_lat1: out_valid=%b want 0", o_ov); end
        step(1'b0, '0, 1'b0, 1'b0);
        total++; if (o_rd) begin bad++; $display("FAIL single_extra_read: rd=%b want 0", o_rd); end
        total++; if (o_ov !== 1'b1 || o_od !== 72'h1 || o_level !== 9'd1) begin
            bad++; $display("FAIL single_out: ov=%b data=%h level=%0d want 1 1 1", o_ov, o_od, o_level);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (!o_pop || o_data !== e_data) begin bad++; $display("FAIL single_pop: pop=%b data=%h want 1 %h", o_pop, o_data, e_data); end
        total++; if (o_level !== '0) begin bad++; $display("FAIL single_level: got %0d want 0", o_level); end
    endtask

    task automatic test_stream();
        logic started = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 72'(i) + 72'h5500_0000_0000, 1'b1, 1'b0);
            total++; if (!o_push) begin bad++; $display("FAIL stream_push: cyc %0d in_ready=%b want 1", i, o_inrdy); end
            total++; if (o_waddr !== e_waddr) begin bad++; $display("FAIL stream_waddr: got %0d want %0d", o_waddr, e_waddr); end
            if (o_rd) begin
                total++; if (o_raddr !== e_raddr) begin bad++; $display("FAIL stream_raddr: got %0d want %0d", o_raddr, e_raddr); end
            end
            if (o_pop) begin
                started = 1'b1;
                total++; if (o_data !== e_data) begin bad++; $display("FAIL stream_data: got %h want %h", o_data, e_data); end
            end else if (started) begin
                total++; bad++; $display("FAIL stream_bubble: cyc %0d pop=0 want 1", i);
            end
            total++; if (o_level !== e_level) begin bad++; $display("FAIL stream_level: got %0d want %0d", o_level, e_level); end
        end
        for (int i = 0; i < 20 && (q.size() > 0 || o_level != 0); i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (o_pop) begin
                total++; if (o_data !== e_data) begin bad++; $display("FAIL stream_drain: got %h want %h", o_data, e_data); end
            end
        end
        total++; if (o_level !== '0 || q.size() != 0) begin bad++; $display("FAIL stream_end: level=%0d left=%0d want 0 0", o_level, q.size()); end
    endtask

    task automatic test_full();
        int acc = 0;
        int cnt = 0;
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 72'(i) + 72'hF000_0000_0000_0000, 1'b0, 1'b0);
            if (o_push) acc++;
            if (o_wr) begin
                total++; if (o_wmask !== 9'h1FF) begin bad++; $display("FAIL full_wmask: got %h want 1ff", o_wmask); end
            end
            total++; if (o_level !== e_level) begin bad++; $display("FAIL full_level: got %0d want %0d", o_level, e_level); end
        end
        total++; if (acc != 258) begin bad++; $display("FAIL full_accepted: got %0d want 258", acc); end
        total++; if (o_level !== 9'd258 || o_inrdy !== 1'b0) begin
            bad++; $display("FAIL full_state: level=%0d in_ready=%b want 258 0", o_level, o_inrdy);
        end
        for (int i = 0; i < 600 && q.size() > 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (o_pop) begin
                cnt++;
                total++; if (o_data !== e_data) begin bad++; $display("FAIL full_drain: got %h want %h", o_data, e_data); end
            end
        end
        total++; if (cnt != 258 || o_level !== '0) begin bad++; $display("FAIL full_drain_end: popped=%0d level=%0d want 258 0", cnt, o_level); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] held;
        for (int i = 0; i < 101; i++) step(1'b1, 72'(i) + 72'hDEAD_0000, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (!o_rd || o_level !== 9'd100) begin bad++; $display("FAIL flush_setup: rd=%b level=%0d want 1 100", o_rd, o_level); end
        held = o_od;
        step(1'b1, 72'hBAD, 1'b1, 1'b1);
        total++; if (o_inrdy || o_wr || o_rd) begin
            bad++; $display("FAIL flush_cycle: in_ready=%b wr=%b rd=%b want 0 0 0", o_inrdy, o_wr, o_rd);
        end
        total++; if (o_level !== '0 || o_ov !== 1'b0 || o_od !== held) begin
            bad++; $display("FAIL flush_after: level=%0d ov=%b data=%h want 0 0 %h", o_level, o_ov, o_od, held);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++; if (o_ov !== 1'b0 || o_level !== '0) begin bad++; $display("FAIL flush_stale: ov=%b level=%0d want 0 0", o_ov, o_level); end
        end
        step(1'b1, 72'h12_3456_789A_BCDE_F012, 1'b0, 1'b0);
        total++; if (o_waddr !== 8'd0) begin bad++; $display("FAIL flush_waddr: got %0d want 0", o_waddr); end
        step(1'b0, '0, 1'b0, 1'b0);
        total++; if (o_raddr !== 8'd0 || !o_rd) begin bad++; $display("FAIL flush_raddr: rd=%b addr=%0d want 1 0", o_rd, o_raddr); end
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (!o_pop || o_data !== 72'h12_3456_789A_BCDE_F012) begin
            bad++; $display("FAIL flush_newword: pop=%b data=%h want 1 123456789abcdef012", o_pop, o_data);
        end
    endtask

    task automatic test_reset_midread();
        step(1'b1, 72'h77, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        total++; if (!o_rd) begin bad++; $display("FAIL midread_issue: rd=%b want 1", o_rd); end
        rst_n = 1'b0;
        #2;
        model_clear();
        total++; if (out_valid !== 1'b0 || level !== '0) begin
            bad++; $display("FAIL midread_reset: ov=%b level=%0d want 0 0", out_valid, level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++; if (o_ov !== 1'b0 || o_level !== '0 || o_rd) begin
                bad++; $display("FAIL midread_spurious: ov=%b level=%0d rd=%b want 0 0 0", o_ov, o_level, o_rd);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 72'({$urandom(), $urandom(), $urandom()}), 1'($urandom_range(0, 1)), 1'b0);
            if (o_pop) begin
                total++; if (o_data !== e_data) begin bad++; $display("FAIL rand_data: cyc %0d got %h want %h", i, o_data, e_data); end
            end
            if (o_wr) begin
                total++; if (o_wmask !== 9'h1FF || o_waddr !== e_waddr || o_web !== 1'b0) begin
                    bad++; $display("FAIL rand_write: mask=%h addr=%0d web=%b want 1ff %0d 0", o_wmask, o_waddr, o_web, e_waddr);
                end
            end
            if (o_rd) begin
                total++; if (o_raddr !== e_raddr) begin bad++; $display("FAIL rand_raddr: got %0d want %0d", o_raddr, e_raddr); end
            end
            if (prev_level < 9'd256) begin
                total++; if (o_inrdy !== 1'b1) begin bad++; $display("FAIL rand_in_ready: got %b want 1 (level %0d)", o_inrdy, prev_level); end
            end
            total++; if (o_level !== e_level) begin bad++; $display("FAIL rand_level: cyc %0d got %0d want %0d", i, o_level, e_level); end
        end
        for (int i = 0; i < 600 && q.size() > 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (o_pop) begin
                total++; if (o_data !== e_data) begin bad++; $display("FAIL rand_drain: got %h want %h", o_data, e_data); end
            end
        end
        total++; if (o_level !== '0 || q.size() != 0) begin bad++; $display("FAIL rand_end: level=%0d left=%0d want 0 0", o_level, q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_full();
        test_flush();
        test_reset_midread();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
